// File: rtl/uart_program_loader.sv
// uart_program_loader
//   Boot-time loader that receives a program over a UART line (8N1, LSB first)
//   and writes it byte-by-byte into instruction memory starting at address 0.
//   The CPU is held in reset until a complete, error-free frame has been stored.
//   Frame format: 0xA5 header, length byte L (L=0 means 256), then N data bytes.
//
// Ports
//   clk             system clock
//   reset           asynchronous, active-low reset
//   rx              UART serial input, idle high, asynchronous to clk
//   start_load      1-cycle pulse: discard current program, wait for a new frame
//   imem_we         instruction memory write strobe (1 cycle per byte)
//   imem_addr       write address
//   imem_wdata      write data
//   cpu_reset_n     0 = hold CPU in reset, 1 = CPU may run
//   load_busy       frame in progress (GET_LEN or GET_DATA)
//   load_done       program stored, CPU released
//   frame_err       sticky error flag (framing error or inter-byte timeout)
//   dbg_proto_state protocol FSM state (WAIT_HDR=0, GET_LEN=1, GET_DATA=2, DONE=3)
//   dbg_rx_state    receiver FSM state (IDLE=0, START=1, DATA=2, STOP=3)
//
// Handshake: there is no back-pressure. The receiver emits a 1-cycle byte_valid
// pulse (cycle T); the write strobe for that byte appears at T+1 for exactly
// one cycle, with address and data held stable during that cycle.
module uart_program_loader #(
  parameter int CLKS_PER_BIT = 16,
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 8,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx,
  input  logic              start_load,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              cpu_reset_n,
  output logic              load_busy,
  output logic              load_done,
  output logic              frame_err,
  output logic [1:0]        dbg_proto_state,
  output logic [1:0]        dbg_rx_state
);

  localparam int HALF   = CLKS_PER_BIT / 2;
  localparam int CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int TO_CYC = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TO_W   = $clog2(TO_CYC);
  localparam int LEN_W  = DATA_W + 1;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [1:0] {WAIT_HDR, GET_LEN, GET_DATA, DONE} proto_state_e;

  // receiver
  logic              rx_s1_q, rx_s2_q, rx_prev_q;
  rx_state_e         rx_state_q, rx_state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              byte_valid_q, byte_valid_d;
  logic              byte_err_q, byte_err_d;

  // protocol
  proto_state_e      state_q, state_d;
  logic              imem_we_q, imem_we_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [DATA_W-1:0] imem_wdata_q, imem_wdata_d;
  logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [LEN_W-1:0]  remain_q, remain_d;
  logic              last_pend_q, last_pend_d;
  logic [TO_W-1:0]   timer_q, timer_d;
  logic              cpu_reset_n_q, cpu_reset_n_d;
  logic              load_busy_q, load_busy_d;
  logic              load_done_q, load_done_d;
  logic              frame_err_q, frame_err_d;

  // Receiver: all timing is relative to the synchronized line rx_s2_q.
  always_comb begin
    rx_state_d   = rx_state_q;
    bit_cnt_d    = bit_cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    byte_err_d   = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        // Edge rather than level, so a line still low after a bad stop bit
        // does not immediately look like a new start bit.
        if (rx_prev_q && !rx_s2_q) begin
          rx_state_d = RX_START;
          bit_cnt_d  = '0;
        end
      end
      RX_START: begin
        if (bit_cnt_q == CNT_W'(HALF - 1)) begin
          bit_cnt_d = '0;
          bit_idx_d = '0;
          rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;  // high at mid-start = glitch
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (bit_cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
          bit_cnt_d = '0;
          shift_d   = {rx_s2_q, shift_q[DATA_W-1:1]};  // LSB arrives first
          if (bit_idx_q == 3'd7) rx_state_d = RX_STOP;
          else                   bit_idx_d  = bit_idx_q + 1'b1;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (bit_cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
          bit_cnt_d    = '0;
          rx_state_d   = RX_IDLE;
          byte_valid_d = rx_s2_q;
          byte_err_d   = !rx_s2_q;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Protocol: start_load overrides everything, including a same-cycle byte.
  always_comb begin
    state_d       = state_q;
    imem_we_d     = 1'b0;
    imem_addr_d   = imem_addr_q;
    imem_wdata_d  = imem_wdata_q;
    wr_cnt_d      = wr_cnt_q;
    remain_d      = remain_q;
    last_pend_d   = 1'b0;
    timer_d       = timer_q;
    cpu_reset_n_d = cpu_reset_n_q;
    load_done_d   = load_done_q;
    frame_err_d   = frame_err_q;
    if (start_load) begin
      state_d       = WAIT_HDR;
      cpu_reset_n_d = 1'b0;
      load_done_d   = 1'b0;
      frame_err_d   = 1'b0;
    end else begin
      if (byte_err_q) frame_err_d = 1'b1;
      case (state_q)
        WAIT_HDR: begin
          if (byte_valid_q && shift_q == DATA_W'(8'hA5)) begin
            state_d = GET_LEN;
            timer_d = TO_W'(TO_CYC - 1);
          end
        end
        GET_LEN, GET_DATA: begin
          if (last_pend_q) begin
            // last strobe is on the bus this cycle; release the CPU next
            state_d       = DONE;
            cpu_reset_n_d = 1'b1;
            load_done_d   = 1'b1;
          end else if (byte_valid_q) begin
            timer_d = TO_W'(TO_CYC - 1);
            if (state_q == GET_LEN) begin
              remain_d = (shift_q == '0) ? LEN_W'(1 << DATA_W) : {1'b0, shift_q};
              wr_cnt_d = '0;
              state_d  = GET_DATA;
            end else begin
              imem_we_d    = 1'b1;
              imem_addr_d  = wr_cnt_q;
              imem_wdata_d = shift_q;
              wr_cnt_d     = wr_cnt_q + 1'b1;
              remain_d     = remain_q - 1'b1;
              last_pend_d  = (remain_q == LEN_W'(1));
            end
          end else if (byte_err_q) begin
            state_d = WAIT_HDR;
          end else if (timer_q == '0) begin
            frame_err_d = 1'b1;
            state_d     = WAIT_HDR;
          end else begin
            timer_d = timer_q - 1'b1;
          end
        end
        default: ;  // DONE: further bytes ignored
      endcase
    end
    load_busy_d = (state_d == GET_LEN) || (state_d == GET_DATA);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_s1_q       <= 1'b1;
      rx_s2_q       <= 1'b1;
      rx_prev_q     <= 1'b1;
      rx_state_q    <= RX_IDLE;
      bit_cnt_q     <= '0;
      bit_idx_q     <= '0;
      shift_q       <= '0;
      byte_valid_q  <= 1'b0;
      byte_err_q    <= 1'b0;
      state_q       <= WAIT_HDR;
      imem_we_q     <= 1'b0;
      imem_addr_q   <= '0;
      imem_wdata_q  <= '0;
      wr_cnt_q      <= '0;
      remain_q      <= '0;
      last_pend_q   <= 1'b0;
      timer_q       <= '0;
      cpu_reset_n_q <= 1'b0;
      load_busy_q   <= 1'b0;
      load_done_q   <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      rx_s1_q       <= rx;
      rx_s2_q       <= rx_s1_q;
      rx_prev_q     <= rx_s2_q;
      rx_state_q    <= rx_state_d;
      bit_cnt_q     <= bit_cnt_d;
      bit_idx_q     <= bit_idx_d;
      shift_q       <= shift_d;
      byte_valid_q  <= byte_valid_d;
      byte_err_q    <= byte_err_d;
      state_q       <= state_d;
      imem_we_q     <= imem_we_d;
      imem_addr_q   <= imem_addr_d;
      imem_wdata_q  <= imem_wdata_d;
      wr_cnt_q      <= wr_cnt_d;
      remain_q      <= remain_d;
      last_pend_q   <= last_pend_d;
      timer_q       <= timer_d;
      cpu_reset_n_q <= cpu_reset_n_d;
      load_busy_q   <= load_busy_d;
      load_done_q   <= load_done_d;
      frame_err_q   <= frame_err_d;
    end
  end

  assign imem_we         = imem_we_q;
  assign imem_addr       = imem_addr_q;
  assign imem_wdata      = imem_wdata_q;
  assign cpu_reset_n     = cpu_reset_n_q;
  assign load_busy       = load_busy_q;
  assign load_done       = load_done_q;
  assign frame_err       = frame_err_q;
  assign dbg_proto_state = state_q;
  assign dbg_rx_state    = rx_state_q;

endmodule

// File: tb/tb_uart_program_loader.sv
// Directed bench for uart_program_loader: drives UART frames on rx, captures
// every write strobe into a queue and compares against hand-built expectations.
module tb_uart_program_loader;

  localparam int CPB = 16;
  localparam int TOB = 32;

  // clock / reset
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx = 1'b1;
  logic       start_load = 1'b0;
  logic       imem_we;
  logic [7:0] imem_addr;
  logic [7:0] imem_wdata;
  logic       cpu_reset_n, load_busy, load_done, frame_err;
  logic [1:0] dbg_proto_state, dbg_rx_state;

  always #5 clk = ~clk;

  uart_program_loader #(
    .CLKS_PER_BIT(CPB), .ADDR_W(8), .DATA_W(8), .TIMEOUT_BITS(TOB)
  ) dut (
    .clk(clk), .reset(reset), .rx(rx), .start_load(start_load),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_reset_n(cpu_reset_n), .load_busy(load_busy), .load_done(load_done),
    .frame_err(frame_err), .dbg_proto_state(dbg_proto_state),
    .dbg_rx_state(dbg_rx_state)
  );

  // scoreboard state
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  int          we_total = 0;
  int          we_wide = 0;
  int          last_we_cyc = -1;
  int          rise_cyc = -1;
  logic        we_prev = 1'b0;
  logic        cpu_prev = 1'b0;

  always @(posedge clk) cyc++;

  // write monitor, sampled on the inactive edge
  always @(negedge clk) begin
    if (reset && imem_we) begin
      got_q.push_back({imem_addr, imem_wdata});
      we_total++;
      last_we_cyc = cyc;
      if (we_prev) we_wide++;
    end
    if (reset && cpu_reset_n && !cpu_prev) rise_cyc = cyc;
    we_prev  = imem_we;
    cpu_prev = cpu_reset_n;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic send_byte(input logic [7:0] b, input logic stop_val = 1'b1);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_val;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk) start_load = 1'b1;
    @(negedge clk) start_load = 1'b0;
  endtask

  task automatic clear_sb();
    exp_q.delete();
    got_q.delete();
    we_total = 0;
    we_wide = 0;
    last_we_cyc = -1;
    rise_cyc = -1;
  endtask

  task automatic check_writes(input string tag);
    int n;
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_wr%0d", tag, i), got_q[i], exp_q[i]);
    chk({tag, "_we_width"}, we_wide, 0);
  endtask

  initial begin
    // reset values
    repeat (3) @(negedge clk);
    chk("rst_we", imem_we, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_wdata", imem_wdata, 0);
    chk("rst_cpu", cpu_reset_n, 0);
    chk("rst_busy", load_busy, 0);
    chk("rst_done", load_done, 0);
    chk("rst_err", frame_err, 0);
    chk("rst_pstate", dbg_proto_state, 0);
    chk("rst_rxstate", dbg_rx_state, 0);
    reset = 1'b1;
    repeat (4) @(negedge clk);

    // 1: basic 3-byte program
    clear_sb();
    send_byte(8'hA5); send_byte(8'h03);
    chk("t1_busy", load_busy, 1);
    send_byte(8'h10); send_byte(8'h21); send_byte(8'hF2);
    repeat (4) @(negedge clk);
    exp_q.push_back(16'h0010); exp_q.push_back(16'h0121); exp_q.push_back(16'h02F2);
    check_writes("t1");
    chk("t1_cpu", cpu_reset_n, 1);
    chk("t1_done", load_done, 1);
    chk("t1_busy_end", load_busy, 0);
    chk("t1_err", frame_err, 0);
    chk("t1_pstate", dbg_proto_state, 3);
    chk("t1_release_cycle", rise_cyc, last_we_cyc + 1);

    // 6a: start_load in DONE drops the CPU on the next cycle
    pulse_start();
    chk("t6_cpu", cpu_reset_n, 0);
    chk("t6_done", load_done, 0);
    chk("t6_pstate", dbg_proto_state, 0);

    // 2: stray bytes before the header are ignored
    clear_sb();
    send_byte(8'h00); send_byte(8'h77);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h3C);
    repeat (4) @(negedge clk);
    exp_q.push_back(16'h003C);
    check_writes("t2");
    chk("t2_done", load_done, 1);
    chk("t2_err", frame_err, 0);

    // 3: length 0 means 256 bytes
    pulse_start();
    clear_sb();
    send_byte(8'hA5); send_byte(8'h00);
    for (int k = 0; k < 256; k++) begin
      send_byte(8'(k));
      exp_q.push_back({8'(k), 8'(k)});
      if (k == 254) chk("t3_not_done_early", load_done, 0);
    end
    repeat (4) @(negedge clk);
    check_writes("t3");
    chk("t3_strobes", we_total, 256);
    chk("t3_done", load_done, 1);
    chk("t3_release_cycle", rise_cyc, last_we_cyc + 1);

    // 4: framing error mid-frame, then recovery with frame_err sticky
    pulse_start();
    clear_sb();
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h11);
    send_byte(8'h22, 1'b0);
    repeat (4) @(negedge clk);
    exp_q.push_back(16'h0011);
    check_writes("t4a");
    chk("t4_err", frame_err, 1);
    chk("t4_pstate", dbg_proto_state, 0);
    chk("t4_cpu", cpu_reset_n, 0);
    chk("t4_busy", load_busy, 0);
    clear_sb();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h99);
    repeat (4) @(negedge clk);
    exp_q.push_back(16'h0099);
    check_writes("t4b");
    chk("t4b_done", load_done, 1);
    chk("t4b_err_sticky", frame_err, 1);

    // 5a: inter-byte timeout
    pulse_start();
    chk("t5_err_cleared", frame_err, 0);
    clear_sb();
    send_byte(8'hA5); send_byte(8'h04); send_byte(8'hAA);
    repeat (TOB * CPB - 120) @(negedge clk);
    chk("t5_busy_before", load_busy, 1);
    chk("t5_err_before", frame_err, 0);
    repeat (200) @(negedge clk);
    exp_q.push_back(16'h00AA);
    check_writes("t5a");
    chk("t5_err", frame_err, 1);
    chk("t5_busy", load_busy, 0);
    chk("t5_cpu", cpu_reset_n, 0);

    // 5b: short low glitch inside a frame produces no byte
    pulse_start();
    clear_sb();
    send_byte(8'hA5); send_byte(8'h02);
    rx = 1'b0;
    repeat (CPB / 2 - 4) @(negedge clk);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    chk("t5_glitch_rxidle", dbg_rx_state, 0);
    send_byte(8'h5A); send_byte(8'h6B);
    repeat (4) @(negedge clk);
    exp_q.push_back(16'h005A); exp_q.push_back(16'h016B);
    check_writes("t5b");
    chk("t5b_done", load_done, 1);

    // 6b: asynchronous reset in the middle of GET_DATA
    pulse_start();
    clear_sb();
    send_byte(8'hA5); send_byte(8'h05); send_byte(8'h01);
    rx = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    chk("t6_busy_pre", load_busy, 1);
    chk("t6_wdata_pre", imem_wdata, 8'h01);
    #2 reset = 1'b0;
    #1;
    chk("t6_rst_we", imem_we, 0);
    chk("t6_rst_addr", imem_addr, 0);
    chk("t6_rst_wdata", imem_wdata, 0);
    chk("t6_rst_cpu", cpu_reset_n, 0);
    chk("t6_rst_busy", load_busy, 0);
    chk("t6_rst_done", load_done, 0);
    chk("t6_rst_err", frame_err, 0);
    chk("t6_rst_pstate", dbg_proto_state, 0);
    chk("t6_rst_rxstate", dbg_rx_state, 0);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
